// File: rtl/wb_regfile_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_regfile_arbiter_pkg;

  localparam int unsigned REG_AW     = 5;
  localparam int unsigned XLEN       = 64;
  localparam int unsigned MD_ENTRY_W = REG_AW + XLEN;

  localparam logic RF_SRC_PIPE = 1'b0;
  localparam logic RF_SRC_MD   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } arb_state_e;

  // One-hot of a destination register; x0 never marks anything pending.
  function automatic logic [31:0] dr_onehot(input logic [REG_AW-1:0] dr);
    logic [31:0] oh;
    oh = '0;
    if (dr != '0) oh[dr] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/wb_md_fifo.sv
// In-order buffer for multiply/divide results awaiting the register-file port.
// Also reports which destinations are still held so decode can stall dependents.
module wb_md_fifo
  import wb_regfile_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [REG_AW-1:0]            push_dr_i,
  input  logic [XLEN-1:0]              push_res_i,
  output logic [REG_AW-1:0]            head_dr_o,
  output logic [XLEN-1:0]              head_res_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic [31:0]                  pend_mask_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [MD_ENTRY_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;

  // Occupancy and per-slot valid bits; push and pop never target the same slot.
  always_comb begin
    valid_d = valid_q;
    count_d = count_q;
    if (pop_i)  valid_d[rd_ptr_q] = 1'b0;
    if (push_i) valid_d[wr_ptr_q] = 1'b1;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers (wrap naturally, DEPTH is a power of two) and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= {push_dr_i, push_res_i};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Pending-destination mask over every occupied slot.
  always_comb begin
    pend_mask_o = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_q[i]) pend_mask_o = pend_mask_o | dr_onehot(mem_q[i][MD_ENTRY_W-1:XLEN]);
    end
  end

  assign head_dr_o  = mem_q[rd_ptr_q][MD_ENTRY_W-1:XLEN];
  assign head_res_o = mem_q[rd_ptr_q][XLEN-1:0];
  assign count_o    = count_q;

endmodule

// File: rtl/wb_regfile_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, MD results
// queue in order, and an aging FSM steals one writeback slot for a starved head.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no aged MD head; age held at 0
// ST_WAIT  | MD head buffered, age counts ungranted cycles
// ST_FORCE | one-cycle slot: writeback stalled, MD head written
module wb_regfile_arbiter
  import wb_regfile_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_v_i,
  input  logic              wb_reg_wen_i,
  input  logic [REG_AW-1:0] wb_dr_i,
  input  logic [XLEN-1:0]   wb_res_i,
  input  logic              md_v_i,
  input  logic [REG_AW-1:0] md_dr_i,
  input  logic [XLEN-1:0]   md_res_i,
  output logic              md_ready_o,
  output logic              out_rf_wen_o,
  output logic [REG_AW-1:0] out_rf_dr_o,
  output logic [XLEN-1:0]   out_rf_data_o,
  output logic              out_rf_src_o,
  output logic              out_wb_stall_o,
  output logic [31:0]       out_md_pend_mask_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned AGE_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e        state_q, state_d;
  logic [AGE_W-1:0]  age_q, age_d, age_inc;
  logic [CNT_W-1:0]  count;
  logic [REG_AW-1:0] head_dr;
  logic [XLEN-1:0]   head_res;
  logic              pipe_req, md_push, md_pop, md_nonempty, force_slot, entries_after;

  assign pipe_req    = wb_v_i && wb_reg_wen_i && (wb_dr_i != '0);
  assign md_ready_o  = (count < CNT_W'(DEPTH));
  assign md_push     = md_v_i && md_ready_o;
  assign md_nonempty = (count != '0);
  assign force_slot  = (state_q == ST_FORCE);
  assign age_inc     = age_q + AGE_W'(1);

  // True when the buffer still holds something after this cycle's push/pop.
  assign entries_after = !(((count == '0) && !md_push) ||
                           ((count == CNT_W'(1)) && md_pop && !md_push));

  wb_md_fifo #(.DEPTH(DEPTH)) u_md_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (md_push),
    .pop_i       (md_pop),
    .push_dr_i   (md_dr_i),
    .push_res_i  (md_res_i),
    .head_dr_o   (head_dr),
    .head_res_o  (head_res),
    .count_o     (count),
    .pend_mask_o (out_md_pend_mask_o)
  );

  // Grant the write port; an MD head targeting x0 still uses the slot but writes nothing.
  always_comb begin
    md_pop         = 1'b0;
    out_rf_wen_o   = 1'b0;
    out_rf_dr_o    = '0;
    out_rf_data_o  = '0;
    out_rf_src_o   = RF_SRC_PIPE;
    out_wb_stall_o = force_slot;
    if (md_nonempty && (force_slot || !pipe_req)) begin
      md_pop        = 1'b1;
      out_rf_src_o  = RF_SRC_MD;
      out_rf_dr_o   = head_dr;
      out_rf_wen_o  = (head_dr != '0);
      out_rf_data_o = out_rf_wen_o ? head_res : '0;
    end else if (pipe_req && !force_slot) begin
      out_rf_wen_o  = 1'b1;
      out_rf_dr_o   = wb_dr_i;
      out_rf_data_o = wb_res_i;
      out_rf_src_o  = RF_SRC_PIPE;
    end
  end

  // Aging FSM next-state and age counter.
  always_comb begin
    state_d = state_q;
    age_d   = age_q;
    case (state_q)
      ST_IDLE: begin
        age_d = '0;
        if (md_nonempty && entries_after) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (md_pop) begin
          age_d   = '0;
          state_d = entries_after ? ST_WAIT : ST_IDLE;
        end else begin
          age_d = age_inc;
          if (age_inc == AGE_W'(STARVE_LIMIT)) state_d = ST_FORCE;
        end
      end
      ST_FORCE: begin
        age_d   = '0;
        state_d = entries_after ? ST_WAIT : ST_IDLE;
      end
      default: begin
        age_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and age registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      age_q   <= '0;
    end else begin
      state_q <= state_d;
      age_q   <= age_d;
    end
  end

endmodule

// File: tb/tb_wb_regfile_arbiter.sv
// Self-checking bench for wb_regfile_arbiter: directed scenarios plus random
// traffic, compared against a queue-based model of the arbitration rules.
module tb_wb_regfile_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_v, wb_wen, md_v;
  logic [4:0]  wb_dr, md_dr;
  logic [63:0] wb_res, md_res;
  logic        md_ready, rf_wen, rf_src, wb_stall;
  logic [4:0]  rf_dr;
  logic [63:0] rf_data;
  logic [31:0] pend_mask;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_regfile_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .wb_v_i             (wb_v),
    .wb_reg_wen_i       (wb_wen),
    .wb_dr_i            (wb_dr),
    .wb_res_i           (wb_res),
    .md_v_i             (md_v),
    .md_dr_i            (md_dr),
    .md_res_i           (md_res),
    .md_ready_o         (md_ready),
    .out_rf_wen_o       (rf_wen),
    .out_rf_dr_o        (rf_dr),
    .out_rf_data_o      (rf_data),
    .out_rf_src_o       (rf_src),
    .out_wb_stall_o     (wb_stall),
    .out_md_pend_mask_o (pend_mask)
  );

  // Reference model: queue of buffered results plus the aging rules.
  typedef struct { logic [4:0] dr; logic [63:0] res; } ent_t;
  ent_t q[$];
  int   m_age;
  bit   m_wait, m_force;
  bit   m_push, m_pop;
  logic        e_wen, e_src, e_stall, e_ready;
  logic [4:0]  e_dr;
  logic [63:0] e_data;
  logic [31:0] e_mask;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_age = 0; m_wait = 0; m_force = 0; m_push = 0; m_pop = 0;
  endfunction

  function automatic void model_eval();
    bit pipe;
    int n;
    n       = q.size();
    pipe    = wb_v && wb_wen && (wb_dr != 0);
    e_ready = (n < DEPTH);
    m_push  = md_v && e_ready;
    m_pop   = 0;
    e_wen = 0; e_src = 0; e_dr = 0; e_data = 0;
    e_stall = m_force;
    if (n > 0 && (m_force || !pipe)) begin
      m_pop  = 1;
      e_src  = 1;
      e_dr   = q[0].dr;
      e_wen  = (q[0].dr != 0);
      e_data = e_wen ? q[0].res : 64'd0;
    end else if (pipe) begin
      e_wen = 1; e_dr = wb_dr; e_data = wb_res;
    end
    e_mask = 0;
    foreach (q[i]) if (q[i].dr != 0) e_mask[q[i].dr] = 1'b1;
  endfunction

  function automatic void model_commit();
    int n0, n1;
    ent_t e;
    n0 = q.size();
    if (m_pop) void'(q.pop_front());
    if (m_push) begin e.dr = md_dr; e.res = md_res; q.push_back(e); end
    n1 = q.size();
    if (m_force) begin
      m_force = 0; m_age = 0; m_wait = (n1 != 0);
    end else if (m_wait) begin
      if (m_pop) begin
        m_age = 0; m_wait = (n1 != 0);
      end else begin
        m_age++;
        if (m_age == LIMIT) begin m_force = 1; m_wait = 0; end
      end
    end else begin
      m_age = 0;
      if (n0 != 0 && n1 != 0) m_wait = 1;
    end
  endfunction

  task automatic check_all();
    chk("rf_wen",    rf_wen,    e_wen);
    chk("rf_dr",     rf_dr,     e_dr);
    chk("rf_data",   rf_data,   e_data);
    chk("rf_src",    rf_src,    e_src);
    chk("wb_stall",  wb_stall,  e_stall);
    chk("pend_mask", pend_mask, e_mask);
    chk("md_ready",  md_ready,  e_ready);
  endtask

  // Inputs are set at a falling edge; outputs checked 1 time unit later.
  task automatic cyc();
    #1;
    model_eval();
    check_all();
    model_commit();
    @(negedge clk);
  endtask

  task automatic set_wb(input logic v, input logic wen, input logic [4:0] dr, input logic [63:0] res);
    wb_v = v; wb_wen = wen; wb_dr = dr; wb_res = res;
  endtask

  task automatic set_md(input logic v, input logic [4:0] dr, input logic [63:0] res);
    md_v = v; md_dr = dr; md_res = res;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    set_wb(0, 0, 0, 0);
    set_md(1, 5'd5, 64'hAA);

    // Reset with MD valid held: everything idle, ready high.
    repeat (3) @(negedge clk);
    #1;
    chk("reset wen",   rf_wen,    0);
    chk("reset dr",    rf_dr,     0);
    chk("reset data",  rf_data,   0);
    chk("reset src",   rf_src,    0);
    chk("reset stall", wb_stall,  0);
    chk("reset mask",  pend_mask, 0);
    chk("reset ready", md_ready,  1);
    @(negedge clk);
    rst_n = 1'b1;

    // First push, then written on the next idle cycle.
    cyc();
    set_md(0, 0, 0);
    #1;
    chk("first mask", pend_mask, 32'h20);
    chk("first dr",   rf_dr,     5);
    chk("first data", rf_data,   64'hAA);
    chk("first src",  rf_src,    1);
    cyc();
    #1;
    chk("first mask cleared", pend_mask, 0);
    cyc();

    // Starvation: continuous pipeline writes vs one MD entry.
    set_wb(1, 1, 5'd3, 64'h11);
    set_md(1, 5'd7, 64'h77);
    cyc();
    set_md(0, 0, 0);
    for (int k = 1; k <= LIMIT + 3; k++) begin
      #1;
      chk("starve stall timing", wb_stall, (k == LIMIT + 2));
      cyc();
    end

    // Fill the buffer while the pipeline writes; MD holds while not ready.
    set_md(1, 5'd1, 64'h101);
    cyc();
    set_md(1, 5'd2, 64'h102);
    cyc();
    set_md(1, 5'd9, 64'h109);
    for (int k = 0; k < 3 * (LIMIT + 3); k++) begin
      cyc();
      if (m_push) set_md(0, 0, 0);
    end

    // x0 handling on both sides.
    set_wb(1, 1, 5'd0, 64'h55);
    set_md(1, 5'd0, 64'hDEAD);
    cyc();
    set_md(1, 5'd12, 64'hC12);
    cyc();
    set_md(0, 0, 0);
    repeat (4) cyc();

    // Push and pop in the same cycle at count 1.
    set_wb(0, 0, 0, 0);
    set_md(1, 5'd4, 64'h44);
    cyc();
    set_md(1, 5'd6, 64'h66);
    cyc();
    set_md(0, 0, 0);
    #1;
    chk("pushpop mask", pend_mask, 32'h40);
    chk("pushpop dr",   rf_dr,     6);
    cyc();
    repeat (2) cyc();

    // Random traffic.
    m_push = 0;
    for (int i = 0; i < 400; i++) begin
      if (!md_v || m_push)
        set_md(($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)), {$urandom, $urandom});
      set_wb(($urandom_range(0, 3) != 0), ($urandom_range(0, 5) != 0),
             ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
             {$urandom, $urandom});
      cyc();
    end
    set_md(0, 0, 0);
    set_wb(0, 0, 0, 0);
    repeat (4) cyc();

    // Reset asserted during a forced slot.
    set_wb(1, 1, 5'd8, 64'h88);
    set_md(1, 5'd10, 64'hA10);
    cyc();
    set_md(0, 0, 0);
    for (int k = 0; k < 20 && !m_force; k++) cyc();
    chk("force reached", m_force, 1);
    #1;
    model_eval();
    check_all();
    #1;
    rst_n = 1'b0;
    set_wb(0, 0, 0, 0);
    #1;
    chk("midreset stall", wb_stall,  0);
    chk("midreset mask",  pend_mask, 0);
    chk("midreset ready", md_ready,  1);
    chk("midreset wen",   rf_wen,    0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    set_md(1, 5'd11, 64'hB11);
    cyc();
    set_md(0, 0, 0);
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
